// File: rtl/mux_arbitro_rr_pkg.sv
// Shared types for the round-robin channel multiplexer.
// Holds the FSM state encoding used by the top level and the bench.
package mux_arbitro_rr_pkg;

  localparam int ESTADO_BITS = 2;

  // 2'b11 is unreachable; the FSM decodes it as IDLE.
  typedef enum logic [ESTADO_BITS-1:0] {
    IDLE    = 2'b00,
    ACTIVO  = 2'b01,
    PAUSADO = 2'b10
  } estado_t;

endpackage

// File: rtl/mux_arbitro_rr_arbitro.sv
// Combinational round-robin arbiter: searches from puntero+1 upwards, wrapping
// modulo CANALES, and returns a one-hot grant (gated by pide) plus the winner index.
module arbitro_rr #(
  parameter  int CANALES  = 4,
  localparam int SEL_BITS = $clog2(CANALES)
) (
  input  logic [CANALES-1:0]  validos,
  input  logic [SEL_BITS-1:0] puntero,
  input  logic                pide,
  output logic [CANALES-1:0]  grant,
  output logic [SEL_BITS-1:0] g
);

  logic encontrado;

  always_comb begin
    grant      = '0;
    g          = puntero;
    encontrado = 1'b0;
    // k runs 1..CANALES so the last granted channel is considered last.
    for (int k = 1; k <= CANALES; k++) begin
      int idx;
      idx = (int'(puntero) + k) % CANALES;
      if (!encontrado && validos[idx]) begin
        encontrado = 1'b1;
        g          = SEL_BITS'(idx);
      end
    end
    if (pide && encontrado) begin
      grant[g] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_arbitro_rr.sv
// N-channel registered multiplexer fed by show-ahead FIFOs, round-robin arbitrated.
// One-cycle latency from grant to salida; pausa or enb=0 blocks grants without popping.
module mux_arbitro_rr
  import mux_arbitro_rr_pkg::*;
#(
  parameter  int DATA_BITS = 4,
  parameter  int CANALES   = 4,
  localparam int SEL_BITS  = $clog2(CANALES)
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic                           enb,
  input  logic                           pausa,
  input  logic [CANALES*DATA_BITS-1:0]   entradas,
  input  logic [CANALES-1:0]             validos,
  output logic [CANALES-1:0]             pop,
  output logic [DATA_BITS-1:0]           salida,
  output logic                           valido_salida,
  output logic [SEL_BITS-1:0]            selector,
  output logic [ESTADO_BITS-1:0]         estado
);

  logic [DATA_BITS-1:0] salida_q, salida_d;
  logic                 valido_q, valido_d;
  logic [SEL_BITS-1:0]  selector_q, selector_d;
  estado_t              estado_q, estado_d;

  logic                pide;
  logic                bloqueado;
  logic [CANALES-1:0]  grant;
  logic [SEL_BITS-1:0] g;

  assign pide      = enb & ~pausa & (|validos);
  assign bloqueado = enb & pausa & (|validos);

  arbitro_rr #(.CANALES(CANALES)) u_arbitro (
    .validos (validos),
    .puntero (selector_q),
    .pide    (pide),
    .grant   (grant),
    .g       (g)
  );

  // Upstream FIFOs share reset_L, so no pop may escape while it is low.
  assign pop = reset_L ? grant : '0;

  always_comb begin
    salida_d   = salida_q;
    valido_d   = 1'b0;
    selector_d = selector_q;
    if (pide) begin
      salida_d   = entradas[int'(g)*DATA_BITS +: DATA_BITS];
      valido_d   = 1'b1;
      selector_d = g;
    end
  end

  always_comb begin
    estado_d = IDLE;
    case (estado_q)
      ACTIVO: begin
        if (pide)           estado_d = ACTIVO;
        else if (bloqueado) estado_d = PAUSADO;
        else                estado_d = IDLE;
      end
      PAUSADO: begin
        if (pide)           estado_d = ACTIVO;
        else if (bloqueado) estado_d = PAUSADO;
        else                estado_d = IDLE;
      end
      default: begin
        if (pide)           estado_d = ACTIVO;
        else if (bloqueado) estado_d = PAUSADO;
        else                estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      salida_q   <= '0;
      valido_q   <= 1'b0;
      selector_q <= SEL_BITS'(CANALES - 1);
      estado_q   <= IDLE;
    end else begin
      salida_q   <= salida_d;
      valido_q   <= valido_d;
      selector_q <= selector_d;
      estado_q   <= estado_d;
    end
  end

  assign salida        = salida_q;
  assign valido_salida = valido_q;
  assign selector      = selector_q;
  assign estado        = estado_q;

endmodule
